// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared vlmul encodings, beat-count helper and scheduler state type
//
// Purpose : common definitions for the vector register-group sequencer.
// Contents: VLMUL_* encodings, vlmul_to_beats(), sched_state_e.
package vrf_pkg;

   localparam logic [2:0] VLMUL_M1 = 3'b000;
   localparam logic [2:0] VLMUL_M2 = 3'b001;
   localparam logic [2:0] VLMUL_M4 = 3'b010;
   localparam logic [2:0] VLMUL_M8 = 3'b011;
   // Any encoding with bit 2 set (1xx) is fractional or reserved.
   localparam int         VLMUL_FRAC_BIT = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } sched_state_e;

   // Number of register beats in a group; fractional/reserved groups occupy one register.
   function automatic logic [3:0] vlmul_to_beats(input logic [2:0] vlmul);
      logic [3:0] beats;
      beats = 4'd1;
      if (!vlmul[VLMUL_FRAC_BIT]) begin
         case (vlmul)
            VLMUL_M1: beats = 4'd1;
            VLMUL_M2: beats = 4'd2;
            VLMUL_M4: beats = 4'd4;
            VLMUL_M8: beats = 4'd8;
            default:  beats = 4'd1;
         endcase
      end
      return beats;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with external pointer
//
// Purpose : grant the first requester at or above ptr (wrapping) while en is high.
// Ports   : req [NUM_REQ]  request vector
//           ptr [ID_W]     highest-priority index for this cycle
//           en             grant enable; gnt is all zero when low
//           gnt [NUM_REQ]  one-hot grant
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt
);

   logic            w_found;
   logic [ID_W-1:0] w_idx;

   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (en && !w_found && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vreg_group_sched.sv
// rtl/vreg_group_sched.sv - round-robin vector register-group address sequencer
//
// Purpose : share one register-group address sequencer between NUM_REQ requesters,
//           emitting one register address per beat with first/last markers.
// Ports   : clk, rst                   clock, async active-high reset
//           req_valid/addr/vlmul       per-requester request (slice i = requester i)
//           req_ready                  one-hot combinational accept
//           flush                      synchronous abort of the current group
//           stall                      downstream backpressure, holds the beat
//           beat_valid/addr/first/last/id  registered beat outputs
//           busy                       group in progress (same as beat_valid)
module vreg_group_sched
   import vrf_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*3-1:0]         req_vlmul,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         flush,
   input  logic                         stall,
   output logic                         beat_valid,
   output logic [ADDR_WIDTH-1:0]        beat_addr,
   output logic                         beat_first,
   output logic                         beat_last,
   output logic [ID_W-1:0]              beat_id,
   output logic                         busy
);

   sched_state_e          r_state;
   logic [ID_W-1:0]       r_rr_ptr;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [3:0]            r_size;
   logic [3:0]            r_offset;
   logic                  r_beat_valid;
   logic [ADDR_WIDTH-1:0] r_beat_addr;
   logic                  r_beat_first;
   logic                  r_beat_last;
   logic [ID_W-1:0]       r_beat_id;

   logic                  w_busy;
   logic                  w_acc;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_any;
   logic [ID_W-1:0]       w_gnt_idx;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic [2:0]            w_gnt_vlmul;
   logic [3:0]            w_beats;
   logic [ID_W-1:0]       w_ptr_nxt;
   logic [3:0]            w_off_nxt;

   assign w_busy = (r_state == BUSY);
   // A new group may start when idle or as the last beat of the current one is consumed.
   assign w_acc  = ~flush & (~w_busy | (r_beat_last & ~stall));

   // Gating with rst keeps req_ready low for the whole reset pulse, not just after an edge.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .en  (w_acc & ~rst),
      .gnt (w_gnt)
   );

   assign req_ready = w_gnt;
   assign w_any     = |w_gnt;

   always_comb begin
      w_gnt_idx   = '0;
      w_gnt_addr  = '0;
      w_gnt_vlmul = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_gnt_idx   = ID_W'(i);
            w_gnt_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_gnt_vlmul = req_vlmul[i*3 +: 3];
         end
      end
   end

   assign w_beats   = vlmul_to_beats(w_gnt_vlmul);
   assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
   assign w_off_nxt = r_offset + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_base       <= '0;
         r_size       <= '0;
         r_offset     <= '0;
         r_beat_valid <= 1'b0;
         r_beat_addr  <= '0;
         r_beat_first <= 1'b0;
         r_beat_last  <= 1'b0;
         r_beat_id    <= '0;
      end else if (flush) begin
         // Remainder of the group is dropped; rr_ptr is left alone.
         r_state      <= IDLE;
         r_beat_valid <= 1'b0;
         r_beat_first <= 1'b0;
         r_beat_last  <= 1'b0;
      end else if (w_any) begin
         r_state      <= BUSY;
         r_rr_ptr     <= w_ptr_nxt;
         r_base       <= w_gnt_addr;
         r_size       <= w_beats;
         r_offset     <= '0;
         r_beat_valid <= 1'b1;
         r_beat_addr  <= w_gnt_addr;
         r_beat_first <= 1'b1;
         r_beat_last  <= (w_beats == 4'd1);
         r_beat_id    <= w_gnt_idx;
      end else if (w_busy && !stall) begin
         if (r_beat_last) begin
            r_state      <= IDLE;
            r_beat_valid <= 1'b0;
            r_beat_first <= 1'b0;
            r_beat_last  <= 1'b0;
         end else begin
            r_offset     <= w_off_nxt;
            // Address wraps modulo 2^ADDR_WIDTH by truncation.
            r_beat_addr  <= r_base + ADDR_WIDTH'(w_off_nxt);
            r_beat_first <= 1'b0;
            r_beat_last  <= (w_off_nxt == (r_size - 4'd1));
         end
      end
   end

   assign beat_valid = r_beat_valid;
   assign beat_addr  = r_beat_addr;
   assign beat_first = r_beat_first;
   assign beat_last  = r_beat_last;
   assign beat_id    = r_beat_id;
   assign busy       = r_beat_valid;

endmodule

// File: tb/tb_vreg_group_sched.sv
// tb/tb_vreg_group_sched.sv - directed self-checking bench for vreg_group_sched
module tb_vreg_group_sched;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          stall = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*3-1:0]  req_vlmul = '0;
   logic [N-1:0]  req_ready;
   logic          beat_valid;
   logic [AW-1:0] beat_addr;
   logic          beat_first;
   logic          beat_last;
   logic [IW-1:0] beat_id;
   logic          busy;
   logic [10:0]   obs;

   int n_cmp = 0;
   int n_err = 0;

   vreg_group_sched #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_vlmul  (req_vlmul),
      .req_ready  (req_ready),
      .flush      (flush),
      .stall      (stall),
      .beat_valid (beat_valid),
      .beat_addr  (beat_addr),
      .beat_first (beat_first),
      .beat_last  (beat_last),
      .beat_id    (beat_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign obs = {beat_valid, busy, beat_first, beat_last, beat_id, beat_addr};

   function automatic logic [10:0] pk(input logic v, input logic f, input logic l,
                                      input logic [IW-1:0] id, input logic [AW-1:0] a);
      return {v, v, f, l, id, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (obs !== 11'd0) begin n_err++; $display("FAIL reset_outputs got %h want %h", obs, 11'd0); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want %b", req_ready, 4'b0000); end
      step();
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready_clk got %b want %b", req_ready, 4'b0000); end
      n_cmp++; if (obs !== 11'd0) begin n_err++; $display("FAIL reset_outputs_clk got %h want %h", obs, 11'd0); end
      req_valid = 4'b0000;
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [10:0] e;
      req_addr[0*AW +: AW] = 5'd8;
      req_vlmul[0*3 +: 3]  = 3'b010;
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b want %b", req_ready, 4'b0001); end
      step();
      req_valid = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         e = pk(1'b1, k == 0, k == 3, 2'd0, AW'(8 + k));
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL single_beat%0d got %h want %h", k, obs, e); end
         step();
      end
      n_cmp++; if ({beat_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_end got %b want 00", {beat_valid, busy}); end
   endtask

   task automatic test_frac_reserved();
      logic [10:0] e;
      req_addr[1*AW +: AW] = 5'd3;
      req_vlmul[1*3 +: 3]  = 3'b111;
      req_valid = 4'b0010;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL frac_ready1 got %b want %b", req_ready, 4'b0010); end
      step();
      req_valid = 4'b0000;
      e = pk(1'b1, 1'b1, 1'b1, 2'd1, 5'd3);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL frac_beat111 got %h want %h", obs, e); end
      req_addr[2*AW +: AW] = 5'd5;
      req_vlmul[2*3 +: 3]  = 3'b100;
      req_valid = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL frac_ready2 got %b want %b", req_ready, 4'b0100); end
      step();
      req_valid = 4'b0000;
      e = pk(1'b1, 1'b1, 1'b1, 2'd2, 5'd5);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL frac_beat100 got %h want %h", obs, e); end
      step();
      n_cmp++; if (beat_valid !== 1'b0) begin n_err++; $display("FAIL frac_end got %b want 0", beat_valid); end
   endtask

   task automatic test_wrap();
      logic [10:0] e;
      req_addr[3*AW +: AW] = 5'd30;
      req_vlmul[3*3 +: 3]  = 3'b011;
      req_valid = 4'b1000;
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ready got %b want %b", req_ready, 4'b1000); end
      step();
      req_valid = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         e = pk(1'b1, k == 0, k == 7, 2'd3, AW'(30 + k));
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL wrap_beat%0d got %h want %h", k, obs, e); end
         step();
      end
      n_cmp++; if (beat_valid !== 1'b0) begin n_err++; $display("FAIL wrap_end got %b want 0", beat_valid); end
   endtask

   task automatic test_back_to_back();
      logic [10:0] e;
      logic [N-1:0] er;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = AW'(10 + i);
         req_vlmul[i*3 +: 3]  = 3'b000;
      end
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         #1;
         er = N'(1) << (g % N);
         n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL b2b_ready%0d got %b want %b", g, req_ready, er); end
         step();
         e = pk(1'b1, 1'b1, 1'b1, IW'(g % N), AW'(10 + g % N));
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL b2b_beat%0d got %h want %h", g, obs, e); end
      end
      req_valid = 4'b0000;
      step();
      n_cmp++; if (beat_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", beat_valid); end
   endtask

   task automatic test_stall();
      logic [10:0] e;
      req_addr[2*AW +: AW] = 5'd20;
      req_vlmul[2*3 +: 3]  = 3'b010;
      req_valid = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_ready got %b want %b", req_ready, 4'b0100); end
      step();
      req_valid = 4'b0000;
      e = pk(1'b1, 1'b1, 1'b0, 2'd2, 5'd20);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_beat0 got %h want %h", obs, e); end
      step();
      e = pk(1'b1, 1'b0, 1'b0, 2'd2, 5'd21);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_beat1 got %h want %h", obs, e); end
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_hold%0d got %h want %h", c, obs, e); end
      end
      stall = 1'b0;
      step();
      e = pk(1'b1, 1'b0, 1'b0, 2'd2, 5'd22);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_beat2 got %h want %h", obs, e); end
      step();
      e = pk(1'b1, 1'b0, 1'b1, 2'd2, 5'd23);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_beat3 got %h want %h", obs, e); end
      // Stalled last beat must not accept a waiting request.
      stall = 1'b1;
      req_addr[0*AW +: AW] = 5'd0;
      req_vlmul[0*3 +: 3]  = 3'b011;
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_last_ready got %b want %b", req_ready, 4'b0000); end
      step();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_last_hold got %h want %h", obs, e); end
      stall = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_release_ready got %b want %b", req_ready, 4'b0001); end
      step();
      req_valid = 4'b0000;
      e = pk(1'b1, 1'b1, 1'b0, 2'd0, 5'd0);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL stall_next_group got %h want %h", obs, e); end
   endtask

   task automatic test_flush();
      logic [10:0] e;
      step();
      e = pk(1'b1, 1'b0, 1'b0, 2'd0, 5'd1);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL flush_beat1 got %h want %h", obs, e); end
      step();
      e = pk(1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL flush_beat2 got %h want %h", obs, e); end
      flush = 1'b1;
      req_valid = 4'b0110;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL flush_ready got %b want %b", req_ready, 4'b0000); end
      step();
      flush = 1'b0;
      n_cmp++; if ({beat_valid, busy, beat_first, beat_last} !== 4'b0000) begin n_err++; $display("FAIL flush_out got %b want 0000", {beat_valid, busy, beat_first, beat_last}); end
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL flush_ptr got %b want %b", req_ready, 4'b0010); end
      req_valid = 4'b0000;
      step();
      n_cmp++; if (beat_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_replay got %b want 0", beat_valid); end
   endtask

   task automatic test_async_reset();
      logic [10:0] e;
      req_addr[1*AW +: AW] = 5'd4;
      req_vlmul[1*3 +: 3]  = 3'b010;
      req_valid = 4'b0010;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL arst_pre_ready got %b want %b", req_ready, 4'b0010); end
      step();
      req_valid = 4'b0000;
      step();
      e = pk(1'b1, 1'b0, 1'b0, 2'd1, 5'd5);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL arst_pre_beat got %h want %h", obs, e); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (obs !== 11'd0) begin n_err++; $display("FAIL arst_outputs got %h want %h", obs, 11'd0); end
      req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL arst_ready got %b want %b", req_ready, 4'b0000); end
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL arst_first_grant got %b want %b", req_ready, 4'b0001); end
      step();
      req_valid = 4'b0000;
      e = pk(1'b1, 1'b1, 1'b0, 2'd0, 5'd0);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL arst_first_beat got %h want %h", obs, e); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_frac_reserved();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
